vec_mac_ctrl: RTL and testbench

- Sequencer for the DSP-based signed 8x8 MAC used in the vector multiplier.
- On a start pulse it reads two length-N operand vectors (input, weight) from a pair of synchronous-read buffers and streams them into the MAC one element per cycle, with dsp_enable and the last-element valid flag aligned to the data.
- It waits for the MAC's output valid, latches the 32-bit dot product, and reports done.
- It sits between the matrix-multiplier top-level scheduler (one row x column per start) and one MAC instance.

---
 rtl/vec_mac_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vec_mac_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mac_ctrl.sv
// vec_mac_ctrl: sequencer feeding one signed 8x8 MAC from a pair of
// synchronous-read operand buffers, then latching the dot product.
// Optional build macro VEC_MAC_TIMEOUT_EN adds a watchdog on the MAC's
// result valid (err_o); without it err_o is a constant 0.
module vec_mac_ctrl #(
  parameter int VEC_LEN = 8,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W:0]          len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic signed [ACC_W-1:0]  result_o,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic signed [DATA_W-1:0] rd_input_i,
  input  logic signed [DATA_W-1:0] rd_weight_i,
  output logic                     dsp_enable_o,
  output logic                     dsp_valid_o,
  output logic signed [DATA_W-1:0] dsp_input_o,
  output logic signed [DATA_W-1:0] dsp_weight_o,
  input  logic                     mac_valid_i,
  input  logic signed [ACC_W-1:0]  mac_result_i,
  output logic                     err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(VEC_LEN);

  state_t              state_q;
  state_t              state_nxt;
  logic                accept;
  logic                last_hit;
  logic                tmo_hit;
  logic [ADDR_W-1:0]   last_addr_q;
  logic                rd_vld_p0;
  logic                rd_last_p0;

  // Saturate the requested length to the buffer depth and return the last
  // address to read; only meaningful for a non-zero length.
  function automatic logic [ADDR_W-1:0] sat_last_addr(input logic [ADDR_W:0] len);
    if (len >= MAX_LEN) begin
      return ADDR_W'(VEC_LEN - 1);
    end
    return ADDR_W'(len - (ADDR_W+1)'(1));
  endfunction

  assign last_hit = (rd_addr_o == last_addr_q);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; start_i is only looked at while idle.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = (len_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (last_hit) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mac_valid_i || tmo_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered control outputs: read sequencing, busy/done and the result.
  // The result changes on the MAC-valid edge; done_o follows one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      last_addr_q <= '0;
      result_o    <= '0;
    end else begin
      busy_o    <= (state_nxt != S_IDLE) || (state_q == S_DONE);
      done_o    <= (state_q == S_DONE);
      rd_en_o   <= (state_nxt == S_FETCH);
      rd_addr_o <= ((state_q == S_FETCH) && (state_nxt == S_FETCH)) ?
                   rd_addr_o + ADDR_W'(1) : '0;
      if (accept) begin
        last_addr_q <= sat_last_addr(len_i);
      end
      if (accept && (len_i == '0)) begin
        result_o <= '0;
      end else if ((state_q == S_WAIT) && mac_valid_i) begin
        result_o <= mac_result_i;
      end else if (tmo_hit) begin
        result_o <= '0;
      end
    end
  end

  // Operand pipeline: buffer data arrives one cycle after the read and is
  // registered onto the MAC port; outside valid cycles the port reads zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_p0    <= 1'b0;
      rd_last_p0   <= 1'b0;
      dsp_enable_o <= 1'b0;
      dsp_valid_o  <= 1'b0;
      dsp_input_o  <= '0;
      dsp_weight_o <= '0;
    end else begin
      // p0: buffer data valid on rd_input_i/rd_weight_i
      rd_vld_p0    <= rd_en_o;
      rd_last_p0   <= rd_en_o && last_hit;
      // p1: element presented to the MAC
      dsp_enable_o <= rd_vld_p0;
      dsp_valid_o  <= rd_last_p0;
      dsp_input_o  <= rd_vld_p0 ? rd_input_i  : '0;
      dsp_weight_o <= rd_vld_p0 ? rd_weight_i : '0;
    end
  end

`ifdef VEC_MAC_TIMEOUT_EN
  // Counter runs only in WAIT; it stops at TIMEOUT-1 on expiry so the DONE
  // cycle can tell a timeout from a normal completion. Needs TIMEOUT >= 2.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] TMO_FLAG = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == S_WAIT) && !mac_valid_i && (tmo_cnt_q == TMO_LAST);

  // Watchdog counter and sticky error flag, cleared by the next accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      err_o     <= 1'b0;
    end else begin
      if (accept) begin
        tmo_cnt_q <= '0;
      end else if ((state_q == S_WAIT) && !mac_valid_i) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
      if (accept) begin
        err_o <= 1'b0;
      end else if ((state_q == S_DONE) && (tmo_cnt_q == TMO_FLAG)) begin
        err_o <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  // Without the watchdog TIMEOUT has no effect; this compare is always false.
  assign err_o   = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_vec_mac_ctrl.sv
// Bench for vec_mac_ctrl: directed runs, a cycle-timeline reference model
// checked on every negedge, and hand-computed literal expectations.
module tb_vec_mac_ctrl;
  localparam int VEC_LEN = 8;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_i, start_i;
  logic [ADDR_W:0]          len_i;
  logic                     busy_o, done_o, rd_en_o;
  logic signed [ACC_W-1:0]  result_o;
  logic [ADDR_W-1:0]        rd_addr_o;
  logic signed [DATA_W-1:0] rd_input_i = '0;
  logic signed [DATA_W-1:0] rd_weight_i = '0;
  logic                     dsp_enable_o, dsp_valid_o;
  logic signed [DATA_W-1:0] dsp_input_o, dsp_weight_o;
  logic                     mac_valid_i;
  logic signed [ACC_W-1:0]  mac_result_i;
  logic                     err_o;

  vec_mac_ctrl #(.VEC_LEN(VEC_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                 .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_input_i(rd_input_i), .rd_weight_i(rd_weight_i),
    .dsp_enable_o(dsp_enable_o), .dsp_valid_o(dsp_valid_o),
    .dsp_input_o(dsp_input_o), .dsp_weight_o(dsp_weight_o),
    .mac_valid_i(mac_valid_i), .mac_result_i(mac_result_i),
    .err_o(err_o));

  // Operand buffers with one-cycle synchronous read.
  logic signed [DATA_W-1:0] in_mem [VEC_LEN];
  logic signed [DATA_W-1:0] wt_mem [VEC_LEN];
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_input_i  <= in_mem[rd_addr_o];
      rd_weight_i <= wt_mem[rd_addr_o];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, en_cnt = 0, rden_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a run accepted in cycle c with length L reads in cycles
  // c+1..c+L, presents element k in cycle c+3+k, waits from c+L+2, and
  // reports done two cycles after the MAC answers.
  bit  m_act = 0, m_zero = 0, m_resp = 0;
  int  m_c = 0, m_L = 0, m_done = NEVER;
  logic signed [DATA_W-1:0] m_in [VEC_LEN];
  logic signed [DATA_W-1:0] m_wt [VEC_LEN];
  logic signed [ACC_W-1:0]  m_res = 0, m_res_val = 0;
  int  m_res_cyc = -1;
  bit  m_err = 0;
  int  m_err_set = -1, m_err_clr = -1;

  initial forever begin
    bit e_rd, e_en, e_done, e_busy;
    int k;
    @(negedge clk);
    if (cyc == m_res_cyc) m_res = m_res_val;
    if (cyc == m_err_set) m_err = 1'b1;
    if (cyc == m_err_clr) m_err = 1'b0;
    k      = cyc - m_c - 3;
    e_rd   = m_act && !m_zero && (cyc >= m_c + 1) && (cyc <= m_c + m_L);
    e_en   = m_act && (k >= 0) && (k < m_L);
    e_done = m_act && (cyc == m_done);
    e_busy = m_act && (cyc >= m_c + 1) && (cyc <= m_done);
    if (chk_en) begin
      check("rd_en", rd_en_o, e_rd);
      if (e_rd) check("rd_addr", rd_addr_o, cyc - m_c - 1);
      check("dsp_enable", dsp_enable_o, e_en);
      check("dsp_valid", dsp_valid_o, e_en && (k == m_L - 1));
      check("dsp_input", dsp_input_o, e_en ? m_in[k] : 0);
      check("dsp_weight", dsp_weight_o, e_en ? m_wt[k] : 0);
      check("done", done_o, e_done);
      check("busy", busy_o, e_busy);
      check("result", result_o, m_res);
      check("err", err_o, m_err);
      done_cnt += int'(done_o);
      en_cnt   += int'(dsp_enable_o);
      rden_cnt += int'(rd_en_o);
    end
    if (rst_i) begin
      m_act = 0; m_res_cyc = cyc + 1; m_res_val = 0;
      m_err_clr = cyc + 1; m_err_set = -1;
    end else begin
      if (m_act && cyc == m_done) m_act = 0;
      if (m_act && !m_zero && !m_resp && cyc >= m_c + m_L + 2) begin
        if (mac_valid_i) begin
          m_resp = 1; m_res_cyc = cyc + 1; m_res_val = mac_result_i; m_done = cyc + 2;
        end
`ifdef VEC_MAC_TIMEOUT_EN
        else if (cyc == m_c + m_L + TIMEOUT) begin
          m_resp = 1; m_res_cyc = cyc + 1; m_res_val = 0; m_done = cyc + 2;
          m_err_set = cyc + 2;
        end
`endif
      end
      if (!m_act && start_i) begin
        m_act = 1; m_resp = 0; m_c = cyc;
        m_L = (int'(len_i) > VEC_LEN) ? VEC_LEN : int'(len_i);
        m_zero = (len_i == 0);
        m_done = m_zero ? cyc + 2 : NEVER;
        if (m_zero) begin m_res_cyc = cyc + 1; m_res_val = 0; end
        m_err_clr = cyc + 1; m_err_set = -1;
        for (int i = 0; i < VEC_LEN; i++) begin
          m_in[i] = in_mem[i]; m_wt[i] = wt_mem[i];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input int n);
    start_i = 1'b1; len_i = (ADDR_W+1)'(n);
    tick();
    start_i = 1'b0; len_i = '0;
  endtask

  task automatic wait_last(input string nm);
    int n = 0;
    while (dsp_valid_o !== 1'b1 && n < 40) begin tick(); n++; end
    n_chk++;
    if (dsp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL %s: dsp_valid_o not seen within 40 cycles", nm);
    end
  endtask

  task automatic wait_done(input string nm, input int lim, output int n);
    n = 0;
    while (done_o !== 1'b1 && n < lim) begin tick(); n++; end
    n_chk++;
    if (done_o !== 1'b1) begin
      n_fail++; $display("FAIL %s: done_o not seen within %0d cycles", nm, lim);
    end
  endtask

  task automatic mac_respond(input int v);
    mac_valid_i = 1'b1; mac_result_i = v;
    tick();
    mac_valid_i = 1'b0; mac_result_i = '0;
  endtask

  function automatic int dot(input int n);
    int s = 0;
    for (int i = 0; i < n && i < VEC_LEN; i++) s += int'(in_mem[i]) * int'(wt_mem[i]);
    return s;
  endfunction

  task automatic clear_counts();
    done_cnt = 0; en_cnt = 0; rden_cnt = 0;
  endtask

  initial begin
    int n, d0;
    rst_i = 1'b1; start_i = 1'b0; len_i = '0;
    mac_valid_i = 1'b0; mac_result_i = '0;
    for (int i = 0; i < VEC_LEN; i++) begin in_mem[i] = '0; wt_mem[i] = '0; end
    tick(); tick();
    chk_en = 1'b1;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_result", result_o, 0);
    check("reset_rd_en", rd_en_o, 0);
    check("reset_dsp_en", dsp_enable_o, 0);
    check("reset_err", err_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // 1: full length, inputs 1..8, weights -1
    for (int i = 0; i < VEC_LEN; i++) begin in_mem[i] = 8'(i + 1); wt_mem[i] = -8'sd1; end
    clear_counts();
    start_run(8);
    wait_last("t1_last");
    tick(); tick();
    mac_respond(dot(8));
    wait_done("t1_done", 20, n);
    check("t1_result", result_o, $signed(32'hFFFFFFDC));
    tick();
    check("t1_busy_after", busy_o, 0);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_enable_cycles", en_cnt, 8);
    check("t1_read_cycles", rden_cnt, 8);

    // 2: extremes of the signed range
    in_mem[0] = -8'sd128; in_mem[1] = 8'sd127;  in_mem[2] = 8'sd5;
    wt_mem[0] = -8'sd128; wt_mem[1] = -8'sd128; wt_mem[2] = 8'sd2;
    clear_counts();
    start_run(3);
    wait_last("t2_last");
    tick();
    mac_respond(dot(3));
    wait_done("t2_done", 20, n);
    check("t2_result", result_o, 138);
    tick();
    check("t2_enable_cycles", en_cnt, 3);

    // 3: zero length
    clear_counts();
    start_run(0);
    wait_done("t3_done", 10, n);
    check("t3_done_latency", n + 1, 2);
    check("t3_result", result_o, 0);
    tick();
    check("t3_reads", rden_cnt, 0);
    check("t3_enables", en_cnt, 0);

    // 3b: length above VEC_LEN saturates to 8 elements
    for (int i = 0; i < VEC_LEN; i++) begin in_mem[i] = 8'(i + 1); wt_mem[i] = 8'sd1; end
    clear_counts();
    start_run(12);
    wait_last("t3b_last");
    tick();
    mac_respond(dot(8));
    wait_done("t3b_done", 20, n);
    check("t3b_result", result_o, 36);
    tick();
    check("t3b_enable_cycles", en_cnt, 8);

    // 4: stray starts while busy, then back-to-back start after done
    in_mem[0] = 3; in_mem[1] = -4; in_mem[2] = 5;  in_mem[3] = -6; in_mem[4] = 7;
    wt_mem[0] = 2; wt_mem[1] = 2;  wt_mem[2] = -3; wt_mem[3] = 1;  wt_mem[4] = -1;
    clear_counts();
    start_run(5);
    tick();
    start_i = 1'b1; len_i = 2; tick(); start_i = 1'b0; len_i = 0;
    wait_last("t4_last");
    start_i = 1'b1; len_i = 1; tick(); start_i = 1'b0; len_i = 0;
    mac_respond(dot(5));
    wait_done("t4a_done", 20, n);
    check("t4a_result", result_o, -30);
    tick();
    in_mem[0] = 10; in_mem[1] = -20; in_mem[2] = 30; in_mem[3] = 40;
    wt_mem[0] = -1; wt_mem[1] = -1;  wt_mem[2] = 1;  wt_mem[3] = 2;
    start_run(4);
    wait_last("t4b_last");
    tick();
    mac_respond(dot(4));
    wait_done("t4b_done", 20, n);
    check("t4b_result", result_o, 120);
    tick();
    check("t4_done_pulses", done_cnt, 2);
    check("t4_enable_cycles", en_cnt, 9);

    // 5: reset in the middle of FETCH, then a stray MAC valid
    for (int i = 0; i < VEC_LEN; i++) begin in_mem[i] = 8'(i + 1); wt_mem[i] = 8'sd3; end
    start_run(8);
    tick(); tick(); tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("t5_busy", busy_o, 0);
    check("t5_rd_en", rd_en_o, 0);
    check("t5_dsp_en", dsp_enable_o, 0);
    check("t5_result", result_o, 0);
    d0 = done_cnt;
    tick();
    mac_respond(99);
    repeat (6) tick();
    check("t5_no_done", done_cnt, d0);

    // 6: MAC never answers
    for (int i = 0; i < VEC_LEN; i++) begin in_mem[i] = 8'(i + 1); wt_mem[i] = 8'sd1; end
    d0 = done_cnt;
    start_run(4);
    wait_last("t6_last");
`ifdef VEC_MAC_TIMEOUT_EN
    wait_done("t6_done", 40, n);
    check("t6_timeout_cycles", n, TIMEOUT);
    check("t6_err", err_o, 1);
    check("t6_result", result_o, 0);
    tick();
    check("t6_err_held", err_o, 1);
    start_run(2);
    check("t6_err_cleared", err_o, 0);
    wait_last("t6b_last");
    mac_respond(dot(2));
    wait_done("t6b_done", 20, n);
    check("t6b_result", result_o, 3);
    check("t6b_err", err_o, 0);
    tick();
`else
    repeat (40) tick();
    check("t6_busy_held", busy_o, 1);
    check("t6_err", err_o, 0);
    check("t6_no_done", done_cnt, d0);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    tick();
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait goes wrong.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_chk);
    $fatal(1, "time limit reached");
  end

endmodule
